// File: rtl/fetch_pkg.sv
// Shared fetch definitions: sequencer states, opcode constants and the
// instruction-length decode also used by the program counter.
package fetch_pkg;

    localparam logic [7:0] OP_HLT  = 8'hF4;
    localparam logic [7:0] OP_1W   = 8'h83;
    localparam logic [7:0] OP_2W_0 = 8'h78;
    localparam logic [7:0] OP_2W_1 = 8'h80;
    localparam logic [7:0] OP_2W_2 = 8'h81;
    localparam logic [7:0] OP_2W_3 = 8'h82;
    localparam logic [7:0] OP_2W_4 = 8'h84;
    localparam logic [7:0] OP_2W_5 = 8'h85;
    localparam logic [7:0] OP_2W_6 = 8'h87;
    localparam logic [7:0] OP_2W_7 = 8'hC0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCapture,
        StIssue,
        StSettle,
        StHalted
    } fetch_state_e;

    // Unlisted opcodes default to three words.
    function automatic logic [1:0] instr_size_of(input logic [7:0] opcode);
        logic [1:0] size;
        case (opcode)
            OP_1W:   size = 2'd1;
            OP_2W_0,
            OP_2W_1,
            OP_2W_2,
            OP_2W_3,
            OP_2W_4,
            OP_2W_5,
            OP_2W_6,
            OP_2W_7: size = 2'd2;
            default: size = 2'd3;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch FSM: reads opcode and operand words from program memory,
// presents the assembled instruction on a valid/ready handshake, pulses pc_load.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W = 6,
    parameter int unsigned       WORD_W = 8,
    parameter logic [WORD_W-1:0] HLT_OP = OP_HLT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_load,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr_opcode,
    output logic [WORD_W-1:0] instr_op1,
    output logic [WORD_W-1:0] instr_op2,
    output logic [1:0]        instr_size,
    output logic              busy,
    output logic              halted
);

    fetch_state_e      state_q;
    logic [1:0]        idx_q;
    logic [WORD_W-1:0] opcode_q;
    logic [WORD_W-1:0] op1_q;
    logic [WORD_W-1:0] op2_q;
    logic [1:0]        size_q;
    logic              mem_rd_q;
    logic              valid_q;
    logic              busy_q;
    logic              halted_q;

    logic [1:0]        cur_size;
    logic              more_words;
    logic              accept;

    always_comb begin
        cur_size   = (idx_q == 2'd0) ? instr_size_of(mem_rdata) : size_q;
        more_words = ({1'b0, idx_q} + 3'd1) < {1'b0, cur_size};
        accept     = (state_q == StIssue) && instr_ready;
        // Halt is issued without advancing the PC.
        pc_load    = accept && (opcode_q != HLT_OP);
        mem_addr   = (state_q == StFetch) ? (pc + ADDR_W'(idx_q)) : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            idx_q    <= 2'd0;
            opcode_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            size_q   <= 2'd0;
            mem_rd_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (run) begin
                        state_q  <= StFetch;
                        idx_q    <= 2'd0;
                        op1_q    <= '0;
                        op2_q    <= '0;
                        mem_rd_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                StFetch: begin
                    state_q  <= StCapture;
                    mem_rd_q <= 1'b0;
                end
                StCapture: begin
                    case (idx_q)
                        2'd0: begin
                            opcode_q <= mem_rdata;
                            size_q   <= cur_size;
                        end
                        2'd1:    op1_q <= mem_rdata;
                        default: op2_q <= mem_rdata;
                    endcase
                    if (more_words) begin
                        idx_q    <= idx_q + 2'd1;
                        state_q  <= StFetch;
                        mem_rd_q <= 1'b1;
                    end else begin
                        state_q <= StIssue;
                        valid_q <= 1'b1;
                    end
                end
                StIssue: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        if (opcode_q == HLT_OP) begin
                            state_q  <= StHalted;
                            halted_q <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            state_q <= StSettle;
                        end
                    end
                end
                StSettle: begin
                    // run is only honoured here, once the PC has moved.
                    if (run) begin
                        state_q  <= StFetch;
                        idx_q    <= 2'd0;
                        op1_q    <= '0;
                        op2_q    <= '0;
                        mem_rd_q <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StHalted: begin
                    state_q <= StHalted;
                end
                default: begin
                    state_q  <= StIdle;
                    mem_rd_q <= 1'b0;
                    valid_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd       = mem_rd_q;
    assign instr_valid  = valid_q;
    assign instr_opcode = opcode_q;
    assign instr_op1    = op1_q;
    assign instr_op2    = op2_q;
    assign instr_size   = size_q;
    assign busy         = busy_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: per-cycle vector table plus directed sequences
// for wrap, halt, run drop and asynchronous reset.
module tb_fetch_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic [5:0] pc = 6'd0;
    logic       pc_load;
    logic       mem_rd;
    logic [5:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic [7:0] instr_opcode;
    logic [7:0] instr_op1;
    logic [7:0] instr_op2;
    logic [1:0] instr_size;
    logic       busy;
    logic       halted;

    logic [7:0] mem [64];

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    fetch_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .pc           (pc),
        .pc_load      (pc_load),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_op1    (instr_op1),
        .instr_op2    (instr_op2),
        .instr_size   (instr_size),
        .busy         (busy),
        .halted       (halted)
    );

    typedef struct packed {
        logic       run;
        logic       ready;
        logic [5:0] pc;
        logic       rd;
        logic [5:0] addr;
        logic       valid;
        logic       pl;
        logic       busy;
        logic [7:0] opc;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [1:0] size;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic rdy, input logic [5:0] p,
                                input logic rd, input logic [5:0] a, input logic v,
                                input logic pl, input logic b, input logic [7:0] opc,
                                input logic [7:0] o1, input logic [7:0] o2,
                                input logic [1:0] sz);
        vec_t t;
        t = {r, rdy, p, rd, a, v, pl, b, opc, o1, o2, sz};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset(input logic [5:0] p);
        reset = 1'b0;
        run = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        pc = p;
        run = 1'b1;
        reset = 1'b1;
    endtask

    task automatic wait_rd(input string name, input logic [5:0] a);
        int k = 0;
        do begin
            step();
            k++;
        end while (!mem_rd && k < 40);
        check({name, "_rd"}, 32'(mem_rd), 32'd1);
        check({name, "_addr"}, 32'(mem_addr), 32'(a));
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        do begin
            step();
            k++;
        end while (!instr_valid && k < 40);
        check({name, "_valid"}, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        int quiet;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[0] = 8'h83;
        mem[1] = 8'h83;
        mem[4] = 8'h10;
        mem[5] = 8'hAA;
        mem[6] = 8'h55;

        //            run rdy pc    rd addr v pl b  opc    op1    op2    size
        vecs[0]  = mk(1, 0, 6'd0, 0, 6'd0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
        vecs[1]  = mk(1, 0, 6'd0, 1, 6'd0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0);
        vecs[2]  = mk(1, 0, 6'd0, 0, 6'd0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0);
        vecs[3]  = mk(1, 1, 6'd0, 0, 6'd0, 1, 1, 1, 8'h83, 8'h00, 8'h00, 2'd1);
        vecs[4]  = mk(1, 0, 6'd1, 0, 6'd0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0);
        vecs[5]  = mk(1, 0, 6'd1, 1, 6'd1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0);
        vecs[6]  = mk(1, 1, 6'd1, 0, 6'd0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0);
        vecs[7]  = mk(1, 1, 6'd1, 0, 6'd0, 1, 1, 1, 8'h83, 8'h00, 8'h00, 2'd1);
        vecs[8]  = mk(1, 0, 6'd4, 0, 6'd0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0);
        vecs[9]  = mk(1, 0, 6'd4, 1, 6'd4, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0);
        vecs[10] = mk(1, 1, 6'd4, 0, 6'd0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0);
        vecs[11] = mk(1, 0, 6'd4, 1, 6'd5, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0);
        vecs[12] = mk(1, 0, 6'd4, 0, 6'd0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0);
        vecs[13] = mk(1, 0, 6'd4, 1, 6'd6, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0);
        vecs[14] = mk(1, 0, 6'd4, 0, 6'd0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0);
        for (int i = 15; i < 20; i++)
            vecs[i] = mk(1, 0, 6'd4, 0, 6'd0, 1, 0, 1, 8'h10, 8'hAA, 8'h55, 2'd3);
        vecs[20] = mk(1, 1, 6'd4, 0, 6'd0, 1, 1, 1, 8'h10, 8'hAA, 8'h55, 2'd3);
        vecs[21] = mk(0, 0, 6'd7, 0, 6'd0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0);
        vecs[22] = mk(0, 0, 6'd7, 0, 6'd0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
        vecs[23] = mk(0, 1, 6'd7, 0, 6'd0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);

        // Reset state before any clock edge after release
        reset = 1'b0;
        #1;
        check("rst_rd", 32'(mem_rd), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_size", 32'(instr_size), 32'd0);

        do_reset(6'd0);
        for (int i = 0; i < NV; i++) begin
            run = vecs[i].run;
            instr_ready = vecs[i].ready;
            pc = vecs[i].pc;
            #1;
            check($sformatf("v%0d_rd", i), 32'(mem_rd), 32'(vecs[i].rd));
            check($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
            check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].valid));
            check($sformatf("v%0d_pc_load", i), 32'(pc_load), 32'(vecs[i].pl));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("v%0d_halted", i), 32'(halted), 32'd0);
            if (vecs[i].valid) begin
                check($sformatf("v%0d_opcode", i), 32'(instr_opcode), 32'(vecs[i].opc));
                check($sformatf("v%0d_op1", i), 32'(instr_op1), 32'(vecs[i].op1));
                check($sformatf("v%0d_op2", i), 32'(instr_op2), 32'(vecs[i].op2));
                check($sformatf("v%0d_size", i), 32'(instr_size), 32'(vecs[i].size));
            end
            @(posedge clock);
            #1;
        end

        // Address wrap, then halt
        mem[63] = 8'h80;
        mem[0]  = 8'h12;
        mem[1]  = 8'hF4;
        mem[2]  = 8'h01;
        mem[3]  = 8'h02;
        do_reset(6'd63);
        wait_rd("wrap_w0", 6'd63);
        wait_rd("wrap_w1", 6'd0);
        wait_valid("wrap");
        check("wrap_opcode", 32'(instr_opcode), 32'h80);
        check("wrap_op1", 32'(instr_op1), 32'h12);
        check("wrap_op2", 32'(instr_op2), 32'h00);
        check("wrap_size", 32'(instr_size), 32'd2);
        instr_ready = 1'b1;
        #1;
        check("wrap_pc_load", 32'(pc_load), 32'd1);
        step();
        instr_ready = 1'b0;
        pc = 6'd1;
        wait_rd("halt_w0", 6'd1);
        wait_valid("halt");
        check("halt_opcode", 32'(instr_opcode), 32'hF4);
        check("halt_size", 32'(instr_size), 32'd3);
        check("halt_op2", 32'(instr_op2), 32'h02);
        instr_ready = 1'b1;
        #1;
        check("halt_no_pc_load", 32'(pc_load), 32'd0);
        step();
        instr_ready = 1'b0;
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_valid", 32'(instr_valid), 32'd0);
        quiet = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (mem_rd || pc_load || !halted) quiet++;
        end
        check("halt_quiet", 32'(quiet), 32'd0);

        // run dropped during CAPTURE of a two-word instruction
        mem[8] = 8'h78;
        mem[9] = 8'h99;
        do_reset(6'd8);
        #1;
        check("drop_halted_cleared", 32'(halted), 32'd0);
        wait_rd("drop_w0", 6'd8);
        step();
        run = 1'b0;
        wait_rd("drop_w1", 6'd9);
        wait_valid("drop");
        check("drop_op1", 32'(instr_op1), 32'h99);
        check("drop_size", 32'(instr_size), 32'd2);
        instr_ready = 1'b1;
        #1;
        check("drop_pc_load", 32'(pc_load), 32'd1);
        step();
        instr_ready = 1'b0;
        pc = 6'd10;
        check("drop_settle_busy", 32'(busy), 32'd1);
        step();
        check("drop_idle_busy", 32'(busy), 32'd0);
        quiet = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (mem_rd || busy) quiet++;
        end
        check("drop_idle_quiet", 32'(quiet), 32'd0);

        // Asynchronous reset in FETCH of the operand word
        do_reset(6'd8);
        wait_rd("arst_w0", 6'd8);
        wait_rd("arst_w1", 6'd9);
        #1;
        reset = 1'b0;
        #1;
        check("arst_rd", 32'(mem_rd), 32'd0);
        check("arst_addr", 32'(mem_addr), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_pc_load", 32'(pc_load), 32'd0);
        check("arst_opcode", 32'(instr_opcode), 32'd0);
        check("arst_size", 32'(instr_size), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
